// File: rtl/nios_pio_pkg.sv
// Shared register map, STATUS bit positions and timer state encoding for the
// timed PIO output peripheral.
package nios_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLR       = 3'd2;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
  localparam logic [2:0] ADDR_PULSE     = 3'd4;
  localparam logic [2:0] ADDR_STATUS    = 3'd5;
  localparam logic [2:0] ADDR_IRQ_EN    = 3'd6;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_IRQ     = 1;
  localparam int STAT_OVERRUN = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PULSING = 1'b1
  } timer_state_e;

endpackage

// File: rtl/nios_pio_pulse_timer.sv
// One-shot pulse timer: prescaler, down counter and IDLE/PULSING FSM.
// done_o is a combinational strobe that is high on the edge ending the pulse.
module nios_pio_pulse_timer
  import nios_pio_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] start_mask_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] mask_o
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             tick;

  assign tick   = (pre_q == PRE_MAX);
  assign done_o = (state_q == ST_PULSING) && tick && (cnt_q == CNT_W'(1));
  assign busy_o = (state_q == ST_PULSING);
  assign mask_o = mask_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    mask_d  = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_PULSING;
          mask_d  = start_mask_i;
          // A zero length still produces a one-tick pulse.
          cnt_d   = (len_i == '0) ? CNT_W'(1) : len_i;
          pre_d   = '0;
        end
      end
      ST_PULSING: begin
        if (tick) begin
          pre_d = '0;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            mask_d  = '0;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: rtl/nios_system_pio_out_timed.sv
// Avalon-MM output PIO with DATA/SET/CLR access plus a one-shot timed pulse
// on selected bits, completion interrupt and overrun flag.
module nios_system_pio_out_timed
  import nios_pio_pkg::*;
#(
  parameter int                 WIDTH       = 8,
  parameter int                 CNT_W       = 16,
  parameter int                 PRESCALE    = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_busy,
  output logic             irq
);

  logic [WIDTH-1:0] out_q, out_d, out_base;
  logic [CNT_W-1:0] len_q, len_d;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic             irq_en_q, irq_en_d;
  logic             wr_en, start, busy, done;
  logic [WIDTH-1:0] wmask, active_mask;
  logic             unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign wmask     = writedata[WIDTH-1:0];
  assign start     = wr_en && (address == ADDR_PULSE) && !busy && (wmask != '0);
  assign unused_wd = ^writedata;

  nios_pio_pulse_timer #(
    .WIDTH   (WIDTH),
    .CNT_W   (CNT_W),
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (start),
    .start_mask_i(wmask),
    .len_i       (len_q),
    .busy_o      (busy),
    .done_o      (done),
    .mask_o      (active_mask)
  );

  // The pulse end is applied first, so a coincident CPU write acts on the
  // already-cleared value.
  assign out_base = done ? (out_q & ~active_mask) : out_q;

  always_comb begin
    out_d    = out_base;
    len_d    = len_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    irq_en_d = irq_en_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:      out_d = wmask;
        ADDR_SET:       out_d = out_base | wmask;
        ADDR_CLR:       out_d = out_base & ~wmask;
        ADDR_PULSE_LEN: len_d = writedata[CNT_W-1:0];
        ADDR_PULSE: begin
          if (busy)       ovr_d = 1'b1;
          else if (start) out_d = out_base | wmask;
        end
        ADDR_STATUS: begin
          if (writedata[STAT_IRQ])     pend_d = 1'b0;
          if (writedata[STAT_OVERRUN]) ovr_d  = 1'b0;
        end
        ADDR_IRQ_EN:    irq_en_d = writedata[0];
        default: ;
      endcase
    end
    if (done) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q    <= RESET_VALUE;
      len_q    <= CNT_W'(1);
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      len_q    <= len_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      irq_en_q <= irq_en_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata = 32'(out_q);
      ADDR_PULSE_LEN: readdata = 32'(len_q);
      ADDR_PULSE:     readdata = 32'(active_mask);
      ADDR_STATUS: begin
        readdata[STAT_BUSY]    = busy;
        readdata[STAT_IRQ]     = pend_q;
        readdata[STAT_OVERRUN] = ovr_q;
      end
      ADDR_IRQ_EN:    readdata[0] = irq_en_q;
      default:        readdata = '0;
    endcase
  end

  assign out_port   = out_q;
  assign pulse_busy = busy;
  assign irq        = pend_q && irq_en_q;

endmodule
